// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: sequencer states, instruction size and default reset PC.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    KILL,
    HOLD
  } fetch_state_e;

  localparam int unsigned INSN_BYTES = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifid_reg.sv
// Pipeline register with flush > hold > load priority; when none applies it inserts a bubble.
module ifid_reg #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  hold_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] ins_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic [ADDR_WIDTH-1:0] pc4_i,
  output logic [DATA_WIDTH-1:0] ins_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] pc4_o,
  output logic                  valid_o
);

  logic [DATA_WIDTH-1:0] ins_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc4_q;
  logic                  valid_q;

  // A flush only kills the valid bit; the data fields keep their last contents.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ins_q   <= '0;
      pc_q    <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (!hold_i) begin
      if (load_i) begin
        ins_q   <= ins_i;
        pc_q    <= pc_i;
        pc4_q   <= pc4_i;
        valid_q <= 1'b1;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign ins_o   = ins_q;
  assign pc_o    = pc_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch front end: owns the PC, runs a single-outstanding req/gnt/rvalid fetch and feeds IF/ID,
// dropping responses that a redirect has made stale and parking one response while Decode stalls.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PCSrc_E,
  input  logic [ADDR_WIDTH-1:0] PCTarget_E,
  input  logic                  Stall_D,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] Ins_D,
  output logic [ADDR_WIDTH-1:0] PC_D,
  output logic [ADDR_WIDTH-1:0] PC_4D,
  output logic                  Valid_D
);

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(INSN_BYTES);

  fetch_state_e          state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] skid_pc_q;
  logic [DATA_WIDTH-1:0] skid_ins_q;

  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] target;
  logic                  ifid_load;
  logic [DATA_WIDTH-1:0] ifid_ins;
  logic [ADDR_WIDTH-1:0] ifid_pc;
  logic [ADDR_WIDTH-1:0] ifid_pc4;

  assign pc_plus4 = pc_q + STEP;
  assign target   = PCTarget_E & ~ADDR_WIDTH'(3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      skid_pc_q  <= '0;
      skid_ins_q <= '0;
    end else begin
      case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (PCSrc_E) begin
            pc_q <= target;
            if (imem_gnt) state_q <= KILL;
          end else if (imem_gnt) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (PCSrc_E) begin
              pc_q    <= target;
              state_q <= REQ;
            end else begin
              pc_q    <= pc_plus4;
              state_q <= Stall_D ? HOLD : REQ;
              if (Stall_D) begin
                skid_ins_q <= imem_rdata;
                skid_pc_q  <= pc_q;
              end
            end
          end else if (PCSrc_E) begin
            pc_q    <= target;
            state_q <= KILL;
          end
        end
        // The granted response is stale; keep tracking redirects until it drains.
        KILL: begin
          if (PCSrc_E) pc_q <= target;
          if (imem_rvalid) state_q <= REQ;
        end
        HOLD: begin
          if (PCSrc_E) begin
            pc_q    <= target;
            state_q <= REQ;
          end else if (!Stall_D) begin
            state_q <= REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    ifid_load = 1'b0;
    ifid_ins  = imem_rdata;
    ifid_pc   = pc_q;
    ifid_pc4  = pc_plus4;
    if (state_q == WAIT && imem_rvalid) begin
      ifid_load = 1'b1;
    end else if (state_q == HOLD) begin
      ifid_load = 1'b1;
      ifid_ins  = skid_ins_q;
      ifid_pc   = skid_pc_q;
      ifid_pc4  = skid_pc_q + STEP;
    end
  end

  assign imem_req  = (state_q == REQ);
  assign imem_addr = imem_req ? pc_q : '0;

  ifid_reg #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ifid (
    .clk_i  (clk),
    .rst_i  (rst),
    .flush_i(PCSrc_E),
    .hold_i (Stall_D),
    .load_i (ifid_load),
    .ins_i  (ifid_ins),
    .pc_i   (ifid_pc),
    .pc4_i  (ifid_pc4),
    .ins_o  (Ins_D),
    .pc_o   (PC_D),
    .pc4_o  (PC_4D),
    .valid_o(Valid_D)
  );

  rvalid_in_window: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> (state_q == WAIT || state_q == KILL));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: randomized memory/hazard stimulus checked against a transaction-level model.
module tb_fetch_sequencer;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrc_E;
  logic [31:0] PCTarget_E;
  logic        Stall_D;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] Ins_D;
  logic [31:0] PC_D;
  logic [31:0] PC_4D;
  logic        Valid_D;

  fetch_sequencer #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .PCSrc_E    (PCSrc_E),
    .PCTarget_E (PCTarget_E),
    .Stall_D    (Stall_D),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .Ins_D      (Ins_D),
    .PC_D       (PC_D),
    .PC_4D      (PC_4D),
    .Valid_D    (Valid_D)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: outstanding fetch, staleness flag, one parked response, next PC in program order.
  bit          busy, killed, bufv, idle;
  logic [31:0] next_pc, buf_addr, buf_data;
  bit          e_valid;
  logic [31:0] e_ins, e_pc, e_pc4;
  bit          mem_pend;
  logic [31:0] mem_addr;
  int unsigned mem_cnt;
  int unsigned lat_min, lat_max;
  int unsigned loads;

  task automatic model_reset();
    busy = 0; killed = 0; bufv = 0; idle = 1;
    next_pc = 32'h0; buf_addr = '0; buf_data = '0;
    e_valid = 0; e_ins = '0; e_pc = '0; e_pc4 = '0;
    mem_pend = 0; mem_addr = '0; mem_cnt = 0;
  endtask

  // Called at a quiet point (#1 after posedge): checks request, drives one cycle, checks IF/ID.
  task automatic step(input bit pcsrc, input logic [31:0] tgt, input bit stall, input bit gnt_en);
    bit          exp_req, gn, rv, ld;
    logic [31:0] la, lw;
    exp_req = !busy && !bufv && !idle;
    check("imem_req", 32'(imem_req), 32'(exp_req));
    check("imem_addr", imem_addr, exp_req ? next_pc : 32'h0);
    gn = imem_req && gnt_en;
    rv = mem_pend && (mem_cnt == 0);
    PCSrc_E     = pcsrc;
    PCTarget_E  = tgt;
    Stall_D     = stall;
    imem_gnt    = gn;
    imem_rvalid = rv;
    imem_rdata  = rv ? (mem_addr ^ KEY) : $urandom;

    ld = 0; la = '0; lw = '0;
    idle = 0;
    if (bufv) begin
      if (pcsrc) bufv = 0;
      else if (!stall) begin ld = 1; la = buf_addr; lw = buf_data; bufv = 0; end
    end
    if (rv) begin
      busy = 0; mem_pend = 0;
      if (!killed && !pcsrc) begin
        if (stall) begin bufv = 1; buf_addr = mem_addr; buf_data = mem_addr ^ KEY; end
        else begin ld = 1; la = mem_addr; lw = mem_addr ^ KEY; end
      end
    end else begin
      if (busy && pcsrc) killed = 1;
      if (mem_pend) mem_cnt--;
    end
    if (gn) begin
      busy = 1; killed = pcsrc; mem_pend = 1; mem_addr = imem_addr;
      mem_cnt = $urandom_range(lat_max, lat_min) - 1;
    end
    if (pcsrc) next_pc = tgt & 32'hFFFF_FFFC;
    else if (ld) next_pc = la + 32'd4;
    if (pcsrc) e_valid = 0;
    else if (!stall) begin
      if (ld) begin e_valid = 1; e_pc = la; e_ins = lw; e_pc4 = la + 32'd4; loads++; end
      else e_valid = 0;
    end

    @(posedge clk);
    #1;
    check("Valid_D", 32'(Valid_D), 32'(e_valid));
    if (e_valid) begin
      check("PC_D", PC_D, e_pc);
      check("Ins_D", Ins_D, e_ins);
      check("PC_4D", PC_4D, e_pc4);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, 32'(imem_req), 32'h0);
    check({tag, "_addr"}, imem_addr, 32'h0);
    check({tag, "_valid"}, 32'(Valid_D), 32'h0);
    check({tag, "_pc"}, PC_D, 32'h0);
    check({tag, "_pc4"}, PC_4D, 32'h0);
    check({tag, "_ins"}, Ins_D, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] saved_pc;
    int unsigned ld0;
    rst = 1'b1; PCSrc_E = 0; PCTarget_E = '0; Stall_D = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    loads = 0; lat_min = 1; lat_max = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // 1-cycle memory, no hazards: one instruction every two cycles.
    repeat (4) step(0, '0, 0, 1);
    ld0 = loads;
    repeat (20) step(0, '0, 0, 1);
    check("throughput", loads - ld0, 32'd10);

    // Decode stall across a response arrival.
    for (int i = 0; i < 10 && !busy; i++) step(0, '0, 0, 1);
    check("stall_setup", 32'(busy), 32'h1);
    saved_pc = e_pc;
    repeat (3) step(0, '0, 1, 1);
    check("stall_hold_pc", PC_D, saved_pc);
    step(0, '0, 0, 1);
    check("stall_release_pc", PC_D, saved_pc + 32'd4);

    // Redirect while a response is in flight.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 10 && !busy; i++) step(0, '0, 0, 1);
    step(1, 32'h100, 0, 1);
    check("redir_wait_valid", 32'(Valid_D), 32'h0);
    for (int i = 0; i < 10 && !imem_req; i++) step(0, '0, 0, 0);
    check("redir_wait_addr", imem_addr, 32'h100);

    // Redirect in the same cycle as the grant.
    lat_min = 2; lat_max = 2;
    step(1, 32'h200, 0, 1);
    for (int i = 0; i < 10 && !imem_req; i++) step(0, '0, 0, 0);
    check("redir_gnt_addr", imem_addr, 32'h200);

    // Unaligned target and PC wrap.
    lat_min = 1; lat_max = 1;
    step(1, 32'h103, 0, 0);
    check("align_addr", imem_addr, 32'h100);
    step(1, 32'hFFFF_FFFC, 0, 0);
    ld0 = loads;
    for (int i = 0; i < 10 && loads == ld0; i++) step(0, '0, 0, 1);
    check("wrap_pc", PC_D, 32'hFFFF_FFFC);
    check("wrap_pc4", PC_4D, 32'h0);

    // Randomized hazards and memory timing.
    lat_min = 1; lat_max = 4;
    ld0 = loads;
    repeat (800) step(($urandom % 10) == 0, $urandom, ($urandom % 4) == 0, $urandom % 2);
    check("random_progress", 32'(loads > ld0 + 50), 32'h1);

    // Asynchronous reset in the middle of a fetch.
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 10 && !busy; i++) step(0, '0, 0, 1);
    check("rst_setup", 32'(busy), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    imem_gnt = 0; imem_rvalid = 0; PCSrc_E = 0; Stall_D = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, '0, 0, 1);
    check("post_rst_addr", imem_addr, 32'h0);
    repeat (30) step(0, '0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controls the instruction-fetch front end: owns the PC register, issues single-outstanding requests to a variable-latency instruction memory over a req/gnt/rvalid handshake, and drives the IF/ID pipeline register. Handles branch/jump redirects from Execute (PCSrc_E/PCTarget_E) and decode stalls (Stall_D), including squashing in-flight responses. Sits between the Execute-stage redirect logic, the hazard unit and the Decode stage.

Parameters:
ADDR_WIDTH, 32, PC/address width in bits
DATA_WIDTH, 32, instruction width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
PCSrc_E  in  1  redirect request from Execute (taken branch/jump)
PCTarget_E  in  ADDR_WIDTH  redirect target
Stall_D  in  1  hold IF/ID contents (from hazard unit)
imem_req  out  1  fetch request valid
imem_addr  out  ADDR_WIDTH  fetch address, stable while imem_req=1 and no grant
imem_gnt  in  1  memory accepts request this cycle
imem_rvalid  in  1  response valid (exactly one per grant, >=1 cycle after gnt)
imem_rdata  in  DATA_WIDTH  response instruction
Ins_D  out  DATA_WIDTH  IF/ID instruction
PC_D  out  ADDR_WIDTH  IF/ID PC
PC_4D  out  ADDR_WIDTH  IF/ID PC+4
Valid_D  out  1  IF/ID holds a live instruction

Behaviour:
- Reset (async, any state): state=IDLE, pc_q=RESET_PC, skid empty, imem_req=0, Ins_D/PC_D/PC_4D=0, Valid_D=0.
- Arithmetic: pc+4 wraps modulo 2^ADDR_WIDTH; PCTarget_E[1:0] forced to 0 on load.
- imem_req=1 only in REQ; imem_addr=pc_q (0 outside REQ).
- FSM:
  - IDLE: one cycle after reset release, no request -> REQ.
  - REQ: if PCSrc_E: pc_q<=target; if gnt also high -> KILL, else stay REQ (address changes; legal, no grant yet). Else if gnt -> WAIT.
  - WAIT: rvalid & PCSrc_E -> drop response, pc_q<=target, -> REQ. rvalid & !Stall_D -> load IF/ID {rdata, pc_q, pc_q+4, Valid_D=1}, pc_q<=pc_q+4, -> REQ. rvalid & Stall_D -> capture into skid, pc_q<=pc_q+4, -> HOLD. PCSrc_E without rvalid -> pc_q<=target, -> KILL.
  - KILL: rvalid -> drop response, -> REQ. Further PCSrc_E updates pc_q, stays KILL until rvalid.
  - HOLD: PCSrc_E -> discard skid, pc_q<=target, -> REQ. Else !Stall_D -> load IF/ID from skid, Valid_D=1, -> REQ.
- IF/ID update priority per edge: PCSrc_E -> Valid_D<=0 (flush; data fields may hold) > Stall_D -> hold all > new instruction delivered -> load > otherwise Valid_D<=0 (bubble).
- Best-case throughput: one instruction per 2 cycles with 1-cycle memory (REQ, WAIT); redirect penalty >=1 bubble.
- Never more than one outstanding request; rvalid outside WAIT/KILL is a protocol error (assertion, ignored by RTL).

Decomposition:
- Shared package fetch_pkg: fetch state enum {IDLE, REQ, WAIT, KILL, HOLD}, INSN_BYTES=4, default RESET_PC.
- Natural sub-module: ifid_reg (IF/ID register with load/hold/flush controls, reusable by later stages).

Test Plan:
- Reset then memory with 1-cycle latency, rdata=addr^32'hA5A5_0000 -> IF/ID sequence PC_D=0,4,8,… Valid_D toggling 1-per-2-cycles, PC_4D=PC_D+4.
- Stall_D held 3 cycles while response arrives at PC=8 -> IF/ID keeps PC_D=4, skid holds PC 8; after release PC_D=8, no duplicate or lost instruction, no request issued during HOLD.
- PCSrc_E=1, PCTarget_E=32'h100 during WAIT (before rvalid) -> Valid_D=0 next cycle, in-flight response dropped, next request imem_addr=32'h100.
- PCSrc_E coincident with imem_gnt in REQ -> KILL, granted response discarded, next request to target.
- PCSrc_E with target 32'h103 -> imem_addr=32'h100; pc_q=32'hFFFF_FFFC fetched -> PC_4D=0 (wrap).
- Assert rst mid-WAIT -> all outputs 0 immediately, first post-reset request to RESET_PC after IDLE cycle.
